// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: XLEN, register index width and the word/address types.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous register-file read port: x0 zero-check and optional write-first
// forwarding, enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] contents [DEPTH],
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic fwd_hit;

  // The x0 check sits ahead of forwarding so a write aimed at x0 never leaks out.
  always_comb begin
    fwd_hit = BYPASS && we && !rst && (wa == ra);
    if (ra == '0)
      rd = '0;
    else if (fwd_hit)
      rd = wd;
    else
      rd = contents[ra];
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports, one synchronous
// write port, x0 hardwired to zero. REGFILE_BYPASS_EN enables write-first forwarding.
module register_file
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem      [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] contents [DEPTH];

  // x0 has no storage; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < DEPTH; i++)
        mem[i[ADDR_WIDTH-1:0]] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    contents[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++)
      contents[i[ADDR_WIDTH-1:0]] = mem[i[ADDR_WIDTH-1:0]];
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_port1 (
    .rst      (rst),
    .ra       (ra1),
    .contents (contents),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rd       (rd1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_port2 (
    .rst      (rst),
    .ra       (ra2),
    .contents (contents),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rd       (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; REGFILE_BYPASS_EN selects the
// same-cycle expectations for the forwarding build.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd, rd1, rd2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk), .rst (rst), .we (we), .wa (wa), .wd (wd),
    .ra1 (ra1), .ra2 (ra2), .rd1 (rd1), .rd2 (rd2)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e1;
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 5'd1,  32'h1111_2222, 5'd1,  5'd0,  32'h1111_2222, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, 5'd2,  32'h3333_4444, 5'd1,  5'd2,  32'h1111_2222, 32'h3333_4444};
    vecs[4] = '{1'b0, 1'b0, 5'd3,  32'hFFFF_FFFF, 5'd3,  5'd1,  32'h0000_0000, 32'h1111_2222};
    vecs[5] = '{1'b0, 1'b1, 5'd5,  32'hA5A5_A5A5, 5'd5,  5'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd1,  32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{1'b0, 1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd30, 32'h8000_0001, 32'h0000_0000};
    vecs[8] = '{1'b0, 1'b1, 5'd30, 32'h7FFF_FFFE, 5'd30, 5'd31, 32'h7FFF_FFFE, 32'h8000_0001};
    vecs[9] = '{1'b0, 1'b1, 5'd31, 32'h0000_FFFF, 5'd31, 5'd30, 32'h0000_FFFF, 32'h7FFF_FFFE};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      @(posedge clk);
      #1;
      rst = 1'b0; we = 1'b0; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp2);
    end

    // Reset clears every register, checked on both ports.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      check($sformatf("rst_rd1_x%0d", a), rd1, 32'h0);
      check($sformatf("rst_rd2_x%0d", 31 - a), rd2, 32'h0);
    end

    // Same-cycle read of a register being written over an old zero.
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D; ra1 = 5'd7; ra2 = 5'd0;
    #1;
    check("rdw_before_rd1", rd1, BYP ? 32'hCAFE_F00D : 32'h0);
    check("rdw_before_rd2", rd2, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("rdw_after_rd1", rd1, 32'hCAFE_F00D);

    // Write aimed at x0 must not forward to a read of x0.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'h5555_AAAA; ra1 = 5'd0; ra2 = 5'd7;
    #1;
    check("x0_fwd_rd1", rd1, 32'h0);
    check("x0_fwd_rd2", rd2, 32'hCAFE_F00D);

    // Reset asserted alongside a write: no forwarding, old value until the edge, then 0.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h0000_0001; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    e1 = 32'hCAFE_F00D;
    check("rst_wr_before_rd1", rd1, e1);
    check("rst_wr_before_rd2", rd2, e1);
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0;
    #1;
    check("rst_wr_after_rd1", rd1, 32'h0);
    check("rst_wr_after_rd2", rd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
